// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA display core: test-pattern modes,
// colour-bar palette and the default 640x480 timing.
package vga_pkg;

    typedef enum logic [1:0] {
        MODE_EXT   = 2'd0,
        MODE_BARS  = 2'd1,
        MODE_CHECK = 2'd2,
        MODE_SOLID = 2'd3
    } mode_t;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // Each bit switches a whole {R,G,B} channel fully on or off.
    localparam logic [2:0] BAR_WHITE   = 3'b111;
    localparam logic [2:0] BAR_YELLOW  = 3'b110;
    localparam logic [2:0] BAR_CYAN    = 3'b011;
    localparam logic [2:0] BAR_GREEN   = 3'b010;
    localparam logic [2:0] BAR_MAGENTA = 3'b101;
    localparam logic [2:0] BAR_RED     = 3'b100;
    localparam logic [2:0] BAR_BLUE    = 3'b001;
    localparam logic [2:0] BAR_BLACK   = 3'b000;

    function automatic logic [2:0] bar_rgb3(input logic [2:0] idx);
        case (idx)
            3'd0:    return BAR_WHITE;
            3'd1:    return BAR_YELLOW;
            3'd2:    return BAR_CYAN;
            3'd3:    return BAR_GREEN;
            3'd4:    return BAR_MAGENTA;
            3'd5:    return BAR_RED;
            3'd6:    return BAR_BLUE;
            default: return BAR_BLACK;
        endcase
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Pixel-clock divider, h/v scan counters and raw active/sync decode of the
// address-stage position.
module vga_timing_gen import vga_pkg::*; #(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int CLK_DIV  = 4,
    parameter int CNT_W    = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             pix_tick,
    output logic             frame_next,
    output logic             frame_start,
    output logic             active,
    output logic             hs,
    output logic             vs
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [DIV_W-1:0] divider;
    logic             running;
    logic             h_last;
    logic             v_last;

    assign pix_tick   = enable && (divider == DIV_W'(CLK_DIV - 1));
    assign h_last     = (h_count == CNT_W'(H_TOTAL - 1));
    assign v_last     = (v_count == CNT_W'(V_TOTAL - 1));
    // The first tick after reset only arms the scan, so frame 0 starts cleanly.
    assign frame_next = pix_tick && (!running || (h_last && v_last));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            divider <= '0;
        end else if (!enable || divider == DIV_W'(CLK_DIV - 1)) begin
            divider <= '0;
        end else begin
            divider <= divider + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_count     <= '0;
            v_count     <= '0;
            running     <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            frame_start <= frame_next;
            if (pix_tick) begin
                if (!running) begin
                    running <= 1'b1;
                end else if (h_last) begin
                    h_count <= '0;
                    v_count <= v_last ? '0 : v_count + 1'b1;
                end else begin
                    h_count <= h_count + 1'b1;
                end
            end
        end
    end

    // Before the scan is armed the position is not part of any frame: keep it blank.
    assign active = running && (h_count < CNT_W'(H_ACTIVE)) && (v_count < CNT_W'(V_ACTIVE));
    assign hs     = running && (h_count >= CNT_W'(H_ACTIVE + H_FP))
                            && (h_count <  CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vs     = running && (v_count >= CNT_W'(V_ACTIVE + V_FP))
                            && (v_count <  CNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/vga_display_core.sv
// VGA display core: timing generator, latency-matching pipeline towards the
// external pixel source, test-pattern colour mux and registered pin drivers.
module vga_display_core import vga_pkg::*; #(
    parameter int H_ACTIVE  = DEF_H_ACTIVE,
    parameter int H_FP      = DEF_H_FP,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BP      = DEF_H_BP,
    parameter int V_ACTIVE  = DEF_V_ACTIVE,
    parameter int V_FP      = DEF_V_FP,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BP      = DEF_V_BP,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CLK_DIV   = 4,
    parameter int PIX_LAT   = 1,
    parameter int COLOR_W   = 4,
    parameter int CNT_W     = 10
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_colour,
    input  logic [3*COLOR_W-1:0] pix_rgb,
    output logic [CNT_W-1:0]     h_count,
    output logic [CNT_W-1:0]     v_count,
    output logic                 pix_tick,
    output logic                 frame_start,
    output logic                 Hsync,
    output logic                 Vsync,
    output logic [COLOR_W-1:0]   vgaRed,
    output logic [COLOR_W-1:0]   vgaGreen,
    output logic [COLOR_W-1:0]   vgaBlue
);

    localparam int BAR_W = H_ACTIVE / 8;

    typedef struct packed {
        logic             active;
        logic             hs;
        logic             vs;
        logic [CNT_W-1:0] h;
        logic             v5;
    } stage_t;

    logic                 t_active, t_hs, t_vs, frame_next;
    stage_t               raw, tap;
    mode_t                mode_q;
    logic [2:0]           bar_idx, bar3;
    logic [3*COLOR_W-1:0] colour, rgb_q;
    logic                 hs_d, vs_d;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CLK_DIV(CLK_DIV), .CNT_W(CNT_W)
    ) u_timing (
        .clk(clk), .reset(reset), .enable(enable),
        .h_count(h_count), .v_count(v_count),
        .pix_tick(pix_tick), .frame_next(frame_next), .frame_start(frame_start),
        .active(t_active), .hs(t_hs), .vs(t_vs)
    );

    assign raw = {t_active, t_hs, t_vs, h_count, v_count[5]};

    // PIX_LAT delay stages; the output register below is the final stage.
    generate
        if (PIX_LAT == 0) begin : g_no_delay
            assign tap = raw;
        end else begin : g_delay
            stage_t dly [PIX_LAT];
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    for (int i = 0; i < PIX_LAT; i++) dly[i] <= '0;
                end else if (pix_tick) begin
                    dly[0] <= raw;
                    for (int i = 1; i < PIX_LAT; i++) dly[i] <= dly[i-1];
                end
            end
            assign tap = dly[PIX_LAT-1];
        end
    endgenerate

    // Mode is captured only on the tick that enters (0,0), so frames never tear.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mode_q <= MODE_EXT;
        end else if (frame_next) begin
            mode_q <= mode_t'(mode);
        end
    end

    always_comb begin
        bar_idx = 3'd0;
        for (int i = 1; i < 8; i++) begin
            if (tap.h >= CNT_W'(i * BAR_W)) bar_idx = 3'(i);
        end
        bar3   = bar_rgb3(bar_idx);
        colour = '0;
        case (mode_q)
            MODE_EXT:   colour = pix_rgb;
            MODE_BARS:  colour = {{COLOR_W{bar3[2]}}, {COLOR_W{bar3[1]}}, {COLOR_W{bar3[0]}}};
            MODE_CHECK: colour = (tap.h[5] ^ tap.v5) ? '1 : '0;
            MODE_SOLID: colour = solid_colour;
        endcase
        if (!tap.active) colour = '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            hs_d  <= 1'b0;
            vs_d  <= 1'b0;
            rgb_q <= '0;
        end else if (pix_tick) begin
            hs_d  <= tap.hs;
            vs_d  <= tap.vs;
            rgb_q <= colour;
        end
    end

    // Disabling blanks the pins immediately while the pipeline keeps its contents.
    assign Hsync = (enable && hs_d) ? HSYNC_POL : ~HSYNC_POL;
    assign Vsync = (enable && vs_d) ? VSYNC_POL : ~VSYNC_POL;
    assign {vgaRed, vgaGreen, vgaBlue} = enable ? rgb_q : '0;

endmodule

// File: tb/tb_vga_display_core.sv
// Randomised self-checking bench: a small-timing core is compared every clock
// against a position/latency model built directly from the display rules.
module tb_vga_display_core;

    localparam int HA = 42, HFP = 2, HSW = 4, HBP = 2, HT = HA + HFP + HSW + HBP;
    localparam int VA = 36, VFP = 1, VSW = 2, VBP = 2, VT = VA + VFP + VSW + VBP;
    localparam int DIV = 3, LAT = 2, CW = 4, NW = 7;
    localparam int FRAME = HT * VT;
    localparam int CYCLES = 45000;
    localparam bit HPOL = 1'b0, VPOL = 1'b1;
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                         12'hF0F, 12'hF00, 12'h00F, 12'h000};

    logic          clk = 1'b0;
    logic          reset, enable;
    logic [1:0]    mode;
    logic [11:0]   solid_colour, pix_rgb;
    logic [NW-1:0] h_count, v_count;
    logic          pix_tick, frame_start, Hsync, Vsync;
    logic [CW-1:0] vgaRed, vgaGreen, vgaBlue;

    vga_display_core #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
        .HSYNC_POL(HPOL), .VSYNC_POL(VPOL), .CLK_DIV(DIV), .PIX_LAT(LAT),
        .COLOR_W(CW), .CNT_W(NW)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .mode(mode),
        .solid_colour(solid_colour), .pix_rgb(pix_rgb),
        .h_count(h_count), .v_count(v_count), .pix_tick(pix_tick),
        .frame_start(frame_start), .Hsync(Hsync), .Vsync(Vsync),
        .vgaRed(vgaRed), .vgaGreen(vgaGreen), .vgaBlue(vgaBlue)
    );

    always #5 clk = ~clk;

    int          tests = 0, failed = 0;
    int          phase, pos, dis_left, rst_left;
    bit          started, exp_fs, mode_done, locked, reset_fired;
    bit          out_hs, out_vs;
    logic [1:0]  mode_lat;
    logic [11:0] out_rgb;
    int          hist[$];

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        if (observed !== expected) begin
            failed++;
            $display("[TB] FAIL %s at %0t: observed %0h, expected %0h", tag, $time, observed, expected);
        end
    endtask

    // Expected colour of scan address a (-1 = no address captured yet).
    function automatic logic [11:0] refColour(int a, logic [1:0] m, logic [11:0] px, logic [11:0] sc);
        int h, v, bar;
        if (a < 0) return 12'h000;
        h = a % HT;
        v = a / HT;
        if (h >= HA || v >= VA) return 12'h000;
        case (m)
            2'd0: return px;
            2'd1: begin
                bar = h / (HA / 8);
                if (bar > 7) bar = 7;
                return BARS[bar];
            end
            2'd2: return (((h / 32) + (v / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
            default: return sc;
        endcase
    endfunction

    function automatic bit refHs(int a);
        int h;
        if (a < 0) return 1'b0;
        h = a % HT;
        return (h >= HA + HFP) && (h < HA + HFP + HSW);
    endfunction

    function automatic bit refVs(int a);
        int v;
        if (a < 0) return 1'b0;
        v = a / HT;
        return (v >= VA + VFP) && (v < VA + VFP + VSW);
    endfunction

    task automatic resetModel();
        phase    = 0;
        pos      = 0;
        started  = 1'b0;
        exp_fs   = 1'b0;
        mode_lat = 2'd0;
        out_hs   = 1'b0;
        out_vs   = 1'b0;
        out_rgb  = 12'h000;
        hist.delete();
        for (int i = 0; i < LAT; i++) hist.push_back(-1);
    endtask

    // One clock edge of the model, using the inputs that were stable at that edge.
    task automatic modelEdge();
        int a;
        exp_fs = 1'b0;
        if (!reset) begin
            resetModel();
            return;
        end
        if (!enable) begin
            phase = 0;
        end else if (phase == DIV - 1) begin
            phase = 0;
            hist.push_back(started ? pos : -1);
            a       = hist.pop_front();
            out_rgb = refColour(a, mode_lat, pix_rgb, solid_colour);
            out_hs  = refHs(a);
            out_vs  = refVs(a);
            if (!started) begin
                started = 1'b1;
                exp_fs  = 1'b1;
            end else begin
                pos    = (pos + 1) % FRAME;
                exp_fs = (pos == 0);
            end
            if (exp_fs) begin
                mode_lat  = mode;
                mode_done = 1'b0;
            end
        end else begin
            phase++;
        end
    endtask

    task automatic compareAll();
        checkOutput("counts", {h_count, v_count}, {NW'(pos % HT), NW'(pos / HT)});
        checkOutput("tick_frame", {pix_tick, frame_start}, {1'(enable && phase == DIV - 1), exp_fs});
        checkOutput("syncs", {Hsync, Vsync},
                    {((enable && out_hs) ? HPOL : ~HPOL), ((enable && out_vs) ? VPOL : ~VPOL)});
        checkOutput("rgb", {vgaRed, vgaGreen, vgaBlue}, enable ? out_rgb : 12'h000);
    endtask

    task automatic applyStimulus(input int cyc);
        pix_rgb = 12'($urandom_range(0, 4095));
        if (rst_left > 0) begin
            rst_left--;
            if (rst_left == 0) reset = 1'b1;
            return;
        end
        if (!reset_fired && cyc > 30000 && started && pos / HT == 10) begin
            mode         = 2'd3;
            solid_colour = 12'h5A3;
            locked       = 1'b1;
            reset_fired  = 1'b1;
            reset        = 1'b0;
            #1;
            resetModel();
            compareAll();
            rst_left = 4;
            return;
        end
        if (dis_left > 0) begin
            dis_left--;
            if (dis_left == 0) enable = 1'b1;
        end else if ($urandom_range(0, 999) < 3) begin
            enable   = 1'b0;
            dis_left = $urandom_range(5, 60);
        end
        if (!locked && started && !mode_done && pos / HT == VA / 2) begin
            mode      = mode + 2'($urandom_range(1, 3));
            mode_done = 1'b1;
        end
        if (!locked && $urandom_range(0, 499) == 0) solid_colour = 12'($urandom_range(0, 4095));
    endtask

    initial begin
        reset        = 1'b0;
        enable       = 1'b1;
        mode         = 2'd0;
        solid_colour = 12'h3C7;
        pix_rgb      = 12'h000;
        dis_left     = 0;
        rst_left     = 0;
        mode_done    = 1'b0;
        locked       = 1'b0;
        reset_fired  = 1'b0;
        resetModel();
        repeat (3) @(posedge clk);
        #1;
        compareAll();
        reset = 1'b1;
        for (int cyc = 0; cyc < CYCLES; cyc++) begin
            @(posedge clk);
            #1;
            modelEdge();
            compareAll();
            applyStimulus(cyc);
        end
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/vga_display_core.md
Name: vga_display_core

Overview:
- Parametrised successor to the fixed 640x480 counter/sync/colour path.
- Generates VGA timing from a programmable pixel-clock divider, with programmable porch, sync and polarity values.
- Exports h/v counts to an external pixel source of configurable read latency, then realigns sync and blanking to that source's data.
- Adds built-in test-pattern modes. Sits between the system clock domain and the board VGA pins.

Parameters:
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, horizontal sync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, visible lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BP, 33, vertical back porch (lines)
- HSYNC_POL, 0, asserted level of Hsync (0 = active-low)
- VSYNC_POL, 0, asserted level of Vsync
- CLK_DIV, 4, clk cycles per pixel tick (1 = every cycle)
- PIX_LAT, 1, external pixel source latency in pixel ticks (0..4)
- COLOR_W, 4, bits per colour channel
- CNT_W, 10, counter width; must hold H_TOTAL-1 and V_TOTAL-1

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- enable  in  1  run timing; low = freeze and blank
- mode  in  2  0 external, 1 colour bars, 2 checkerboard, 3 solid
- solid_colour  in  3*COLOR_W  {R,G,B} colour for mode 3
- pix_rgb  in  3*COLOR_W  {R,G,B} from external source, valid PIX_LAT ticks after the address
- h_count  out  CNT_W  current horizontal count (address stage)
- v_count  out  CNT_W  current vertical count (address stage)
- pix_tick  out  1  one-clk pulse when counters advance
- frame_start  out  1  one-clk pulse when h=0,v=0 is entered
- Hsync  out  1  horizontal sync, aligned with RGB
- Vsync  out  1  vertical sync, aligned with RGB
- vgaRed  out  COLOR_W  red channel
- vgaGreen  out  COLOR_W  green channel
- vgaBlue  out  COLOR_W  blue channel

Behaviour:
- Totals: H_TOTAL = sum of the H_* parameters; V_TOTAL = sum of the V_* parameters.
- Reset values:
  - divider, h_count, v_count = 0; pix_tick = 0; frame_start = 0.
  - Hsync = ~HSYNC_POL; Vsync = ~VSYNC_POL.
  - RGB = 0; latched mode = 0.
- Divider counts 0..CLK_DIV-1. pix_tick is asserted when divider = CLK_DIV-1 and enable = 1. With CLK_DIV = 1, pix_tick = enable.
- On pix_tick:
  - h_count increments; at H_TOTAL-1 it wraps to 0 and v_count increments.
  - v_count wraps from V_TOTAL-1 to 0.
- frame_start is a registered pulse on the tick that moves the counters to (0,0).
- Raw decode from the address-stage counters:
  - active = h < H_ACTIVE && v < V_ACTIVE
  - hs = H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC
  - vs = same form on v with the V_* parameters.
- Alignment pipeline:
  - Depth PIX_LAT+1 stages, advancing only on pix_tick; carries {active, hs, vs, h-bits, v-bits}.
  - External pixel data is sampled on the final stage.
  - Net result: Hsync, Vsync and RGB change together, PIX_LAT+1 ticks after the counters.
- Mode latch: mode is sampled only on frame_start (no mid-frame tearing). Mode changes take effect on the next frame.
- Colour select (final stage, registered); F = all ones of COLOR_W.
  - Mode 0: pix_rgb.
  - Mode 1: 8 equal vertical bars, width H_ACTIVE/8 (integer division; the remainder extends the last bar). Order: white, yellow, cyan, green, magenta, red, blue, black.
  - Mode 2: h[5]^v[5] ? white : black (32x32 cells).
  - Mode 3: solid_colour.
- Blanking: RGB = 0 whenever the delayed active is 0, regardless of mode.
- Sync outputs: Hsync = hs_d ? HSYNC_POL : ~HSYNC_POL; Vsync likewise.
- enable low:
  - Divider is cleared; counters and pipeline hold.
  - Hsync/Vsync driven to their inactive level; RGB = 0.
  - On re-enable, resume from the held counts; first pix_tick after CLK_DIV cycles.
- Reset mid-frame: everything returns to reset values immediately (async). Counting restarts at (0,0) on the first tick after deassertion; frame_start fires at that point.
- Simultaneous h wrap and v wrap on the same tick: both wrap; frame_start asserts.

Decomposition:
- Package vga_pkg:
  - mode enum: MODE_EXT, MODE_BARS, MODE_CHECK, MODE_SOLID
  - bar colour constants in 3-bit R/G/B form, expanded to COLOR_W
  - default 640x480 timing localparams
- Sub-module vga_timing_gen: divider, counters, raw active/hs/vs decode, frame_start.
- The top level holds the alignment pipeline and the colour mux.

Test Plan:
- Small timing (H 8/2/3/3 = 16, V 4/1/1/2 = 8), CLK_DIV = 1, PIX_LAT = 1 -> Hsync low for exactly 3 ticks per 16, starting 2 ticks after h = 10. Vsync low for 16 ticks per 128. frame_start every 128 clk.
- Default params, CLK_DIV = 4 -> line = 3200 clk, frame = 1,680,000 clk. Hsync low 384 clk per line. RGB = 0 when h >= 640 (delayed).
- Mode 0, pix_rgb = h_count[3:0] replicated, PIX_LAT = 2 -> vgaRed at output equals the h value from 3 ticks earlier. First visible pixel is 0 and coincides with Hsync timing offset.
- Mode switched 0 -> 1 mid-frame -> output unchanged until the next frame_start. Next frame shows bar 0 = 0xFFF, bar 5 = 0xF00, bar 7 = 0x000; width 80 pixels at default params.
- enable low for 50 clk mid-line -> h/v frozen, syncs inactive, RGB 0. After release, h continues from the held value; no frame_start spurious pulse.
- Assert reset (low) mid-frame with mode 3, solid_colour 0x5A3 -> outputs at reset values within the same cycle. After release, the first visible pixel is 0x000 until frame_start latches mode, then 0x5A3 from line 0.
